// File: rtl/pixel_scheduler.sv
// pixel_scheduler
//   Walks every pixel of a frame in raster order, derives the complex
//   constant c for each pixel from the viewport latched at frame start,
//   launches one depth calculation at a time and streams the results out
//   through a valid/ready handshake.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no frame in progress, waiting for frame_start
//   ISSUE  | one-cycle calc_start pulse for the current pixel
//   WAIT   | waiting for the calculator to report calc_done
//   OUTPUT | pixel presented downstream, waiting for out_ready
//
// Ports
//   sysclk, reset          clock and synchronous active-high reset
//   frame_start            single-cycle request to render one frame
//   re_min, im_max, step   viewport: left column re, top line im, pixel pitch
//   re_c, im_c             c of the current pixel, to the calculator
//   calc_start             one-cycle launch pulse to the calculator
//   calc_done, calc_depth  level result-ready and depth from the calculator
//   out_valid, out_ready   downstream pixel handshake
//   out_x, out_y           coordinates of the presented pixel
//   out_depth, out_last    depth and last-pixel-of-frame flag
//   busy                   frame in progress
//   frame_done             one-cycle pulse after the last pixel is accepted
module pixel_scheduler #(
  parameter int FRAC        = 60,
  parameter int WORD_LENGTH = 64,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic signed [WORD_LENGTH-1:0] re_min,
  input  logic signed [WORD_LENGTH-1:0] im_max,
  input  logic signed [WORD_LENGTH-1:0] step,
  output logic signed [WORD_LENGTH-1:0] re_c,
  output logic signed [WORD_LENGTH-1:0] im_c,
  output logic                          calc_start,
  input  logic                          calc_done,
  input  logic [9:0]                    calc_depth,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [9:0]                    out_x,
  output logic [9:0]                    out_y,
  output logic [9:0]                    out_depth,
  output logic                          out_last,
  output logic                          busy,
  output logic                          frame_done
);

  // The coordinate arithmetic never looks at the binary point; FRAC only
  // has to describe a format that fits in the word.
  if (FRAC < 0 || FRAC >= WORD_LENGTH) begin : g_frac_range
    $error("pixel_scheduler: FRAC must lie inside the coordinate word");
  end
  if (H_RES < 2 || H_RES > 1024 || V_RES < 2 || V_RES > 1024) begin : g_res_range
    $error("pixel_scheduler: H_RES/V_RES must be 2..1024 for 10-bit coordinates");
  end

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t state, state_nxt;

  logic signed [WORD_LENGTH-1:0] re_min_q, re_min_nxt;
  logic signed [WORD_LENGTH-1:0] step_q, step_nxt;
  logic signed [WORD_LENGTH-1:0] re_acc, re_acc_nxt;
  logic signed [WORD_LENGTH-1:0] im_acc, im_acc_nxt;
  logic [9:0]                    x_q, x_nxt;
  logic [9:0]                    y_q, y_nxt;
  logic [9:0]                    depth_q, depth_nxt;
  logic                          frame_done_q, frame_done_nxt;
  logic                          at_last;

  assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state        <= S_IDLE;
      re_min_q     <= '0;
      step_q       <= '0;
      re_acc       <= '0;
      im_acc       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      depth_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      re_min_q     <= re_min_nxt;
      step_q       <= step_nxt;
      re_acc       <= re_acc_nxt;
      im_acc       <= im_acc_nxt;
      x_q          <= x_nxt;
      y_q          <= y_nxt;
      depth_q      <= depth_nxt;
      frame_done_q <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    re_min_nxt     = re_min_q;
    step_nxt       = step_q;
    re_acc_nxt     = re_acc;
    im_acc_nxt     = im_acc;
    x_nxt          = x_q;
    y_nxt          = y_q;
    depth_nxt      = depth_q;
    frame_done_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_start) begin
          re_min_nxt = re_min;
          step_nxt   = step;
          re_acc_nxt = re_min;
          im_acc_nxt = im_max;
          x_nxt      = '0;
          y_nxt      = '0;
          state_nxt  = S_ISSUE;
        end
      end

      // calc_done may still be high from the previous pixel here, so it is
      // deliberately not looked at until WAIT.
      S_ISSUE: state_nxt = S_WAIT;

      S_WAIT: begin
        if (calc_done) begin
          depth_nxt = calc_depth;
          state_nxt = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        if (out_ready) begin
          if (at_last) begin
            frame_done_nxt = 1'b1;
            state_nxt      = S_IDLE;
          end else begin
            if (x_q != X_LAST) begin
              x_nxt      = x_q + 10'd1;
              re_acc_nxt = re_acc + step_q;
            end else begin
              x_nxt      = '0;
              y_nxt      = y_q + 10'd1;
              re_acc_nxt = re_min_q;
              im_acc_nxt = im_acc - step_q;
            end
            state_nxt = S_ISSUE;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign re_c       = re_acc;
  assign im_c       = im_acc;
  assign calc_start = (state == S_ISSUE);
  assign out_valid  = (state == S_OUTPUT);
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign out_depth  = depth_q;
  assign out_last   = (state == S_OUTPUT) && at_last;
  assign busy       = (state != S_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
module tb_pixel_scheduler;

  localparam int WL = 64;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int N  = H * V;

  logic          sysclk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic [WL-1:0] re_min = '0;
  logic [WL-1:0] im_max = '0;
  logic [WL-1:0] step = '0;
  logic [WL-1:0] re_c;
  logic [WL-1:0] im_c;
  logic          calc_start;
  logic          calc_done = 1'b0;
  logic [9:0]    calc_depth = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [9:0]    out_x;
  logic [9:0]    out_y;
  logic [9:0]    out_depth;
  logic          out_last;
  logic          busy;
  logic          frame_done;

  pixel_scheduler #(.FRAC(60), .WORD_LENGTH(WL), .H_RES(H), .V_RES(V)) dut (
    .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
    .re_min(re_min), .im_max(im_max), .step(step),
    .re_c(re_c), .im_c(im_c), .calc_start(calc_start),
    .calc_done(calc_done), .calc_depth(calc_depth),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_depth(out_depth), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the viewport of the frame being rendered and the
  // arithmetic definition of c for the k-th pixel in raster order.
  logic [63:0] m_re_min, m_im_max, m_step;
  int          launch_k = 0;
  int          lat_min = 5;
  int          lat_max = 5;
  bit          sticky = 1'b0;
  logic [63:0] re_cap[$];

  function automatic logic [63:0] exp_re(input int k);
    return m_re_min + 64'(k % H) * m_step;
  endfunction

  function automatic logic [63:0] exp_im(input int k);
    return m_im_max - 64'(k / H) * m_step;
  endfunction

  // Calculator model: returns the launch index as depth after a random
  // latency; in sticky mode calc_done stays high until the next launch.
  int          c_cnt = 0;
  bit          c_pending = 1'b0;
  logic [9:0]  c_depth = '0;
  logic [63:0] c_re, c_im;

  always @(negedge sysclk) begin
    if (reset) begin
      c_pending = 1'b0;
    end else if (calc_start) begin
      check("re_c_at_launch", re_c, exp_re(launch_k));
      check("im_c_at_launch", im_c, exp_im(launch_k));
      re_cap.push_back(re_c);
      c_re      = re_c;
      c_im      = im_c;
      c_depth   = 10'(launch_k);
      launch_k++;
      calc_done = 1'b0;
      c_cnt     = $urandom_range(lat_max, lat_min);
      c_pending = 1'b1;
    end else if (c_pending) begin
      check("re_c_held", re_c, c_re);
      check("im_c_held", im_c, c_im);
      if (c_cnt <= 1) begin
        calc_done  = 1'b1;
        calc_depth = c_depth;
        c_pending  = 1'b0;
      end else begin
        c_cnt--;
      end
    end else if (!sticky) begin
      calc_done = 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_re_c"}, re_c, 64'd0);
    check({tag, "_im_c"}, im_c, 64'd0);
    check({tag, "_calc_start"}, 64'(calc_start), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_x"}, 64'(out_x), 64'd0);
    check({tag, "_out_y"}, 64'(out_y), 64'd0);
    check({tag, "_out_depth"}, 64'(out_depth), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
  endtask

  // ready_mode: 0 random, 1 always ready, 2 ready except 10 cycles on pixel 2
  task automatic run_frame(input logic [63:0] rmin, input logic [63:0] imax,
                           input logic [63:0] stp, input int ready_mode,
                           input bit perturb);
    int          k = 0;
    int          cyc = 0;
    int          hold = 0;
    bit          fin = 1'b0;
    bit          have_snap = 1'b0;
    bit          rdy;
    logic [30:0] snap = '0;
    m_re_min = rmin;
    m_im_max = imax;
    m_step   = stp;
    launch_k = 0;
    re_cap.delete();
    @(negedge sysclk);
    re_min = rmin;
    im_max = imax;
    step = stp;
    frame_start = 1'b1;
    @(negedge sysclk);
    frame_start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("launch_after_start", 64'(calc_start), 64'd1);
    while (!fin && cyc < 3000) begin
      if (perturb) begin
        frame_start = (cyc == 7);
        if (cyc == 7) begin
          re_min = ~rmin;
          im_max = {$urandom, $urandom};
          step   = {$urandom, $urandom};
        end
      end
      if (out_valid) begin
        check("no_launch_in_output", 64'(calc_start), 64'd0);
        if (have_snap)
          check("stall_stable", 64'({out_x, out_y, out_depth, out_last}), 64'(snap));
        case (ready_mode)
          0: rdy = 1'($urandom_range(1, 0));
          1: rdy = 1'b1;
          default: begin
            rdy = !(k == 2 && hold < 10);
            if (!rdy) hold++;
          end
        endcase
        if (rdy) begin
          check("out_x", 64'(out_x), 64'(k % H));
          check("out_y", 64'(out_y), 64'(k / H));
          check("out_depth", 64'(out_depth), 64'(k));
          check("out_last", 64'(out_last), 64'(k == N - 1));
          out_ready = 1'b1;
          have_snap = 1'b0;
          k++;
          @(negedge sysclk);
          cyc++;
          out_ready = 1'b0;
          if (k == N) begin
            check("frame_done_pulse", 64'(frame_done), 64'd1);
            check("idle_after_last", 64'(busy), 64'd0);
            fin = 1'b1;
          end else begin
            check("launch_after_handshake", 64'(calc_start), 64'd1);
          end
          continue;
        end
        snap = {out_x, out_y, out_depth, out_last};
        have_snap = 1'b1;
        out_ready = 1'b0;
      end else begin
        out_ready = (ready_mode == 0) ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      @(negedge sysclk);
      cyc++;
    end
    frame_start = 1'b0;
    out_ready = 1'b0;
    check("frame_completed", 64'(fin), 64'd1);
    check("pixel_count", 64'(k), 64'(N));
    check("launch_count", 64'(launch_k), 64'(N));
    @(negedge sysclk);
    check("frame_done_single", 64'(frame_done), 64'd0);
  endtask

  initial begin
    bit any_start = 1'b0;
    bit any_valid = 1'b0;
    bit any_busy  = 1'b0;

    // reset state
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    check_zero("reset");

    // reset in the middle of WAIT, stale calc_done afterwards
    lat_min = 8;
    lat_max = 8;
    sticky = 1'b1;
    m_re_min = 64'h1234; m_im_max = 64'h5678; m_step = 64'h10;
    launch_k = 0;
    re_min = m_re_min; im_max = m_im_max; step = m_step;
    frame_start = 1'b1;
    @(negedge sysclk);
    frame_start = 1'b0;
    repeat (3) @(negedge sysclk);
    check("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge sysclk);
    check_zero("mid_reset");
    reset = 1'b0;
    calc_done = 1'b1;
    calc_depth = 10'h155;
    repeat (20) begin
      @(negedge sysclk);
      any_start |= calc_start;
      any_valid |= out_valid;
      any_busy  |= busy;
    end
    check("no_launch_after_reset", 64'(any_start), 64'd0);
    check("stale_done_ignored", 64'(any_valid), 64'd0);
    check("idle_after_reset", 64'(any_busy), 64'd0);
    calc_done = 1'b0;
    sticky = 1'b0;

    // directed viewport: re -2.0, im 1.0, step 0.5
    lat_min = 5;
    lat_max = 5;
    run_frame(64'hE000_0000_0000_0000, 64'h1000_0000_0000_0000,
              64'h0800_0000_0000_0000, 1, 1'b0);
    check("re_seq0", re_cap[0], 64'hE000_0000_0000_0000);
    check("re_seq1", re_cap[1], 64'hE800_0000_0000_0000);
    check("re_seq2", re_cap[2], 64'hF000_0000_0000_0000);
    check("re_seq3", re_cap[3], 64'hF800_0000_0000_0000);
    check("re_seq4", re_cap[4], 64'hE000_0000_0000_0000);

    // back-pressure on pixel (2,0)
    run_frame(64'hE000_0000_0000_0000, 64'h1000_0000_0000_0000,
              64'h0800_0000_0000_0000, 2, 1'b0);

    // calc_done left high between pixels, random latency and readiness
    sticky = 1'b1;
    lat_min = 1;
    lat_max = 6;
    run_frame({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0);

    // frame_start and viewport changes mid-frame
    sticky = 1'b0;
    run_frame({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b1);

    // wrap of the real accumulator
    run_frame(64'h7FFF_FFFF_FFFF_FFFF, {$urandom, $urandom}, 64'd1, 1, 1'b0);
    check("re_wrap", re_cap[1], 64'h8000_0000_0000_0000);

    // further random frames
    for (int f = 0; f < 3; f++) begin
      sticky = 1'($urandom_range(1, 0));
      run_frame({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
